// File: rtl/assert_event_arbiter.sv
// Collects one-cycle violation strobes from the assertion monitors, arbitrates them
// round-robin into a show-ahead report FIFO and keeps sticky/counter/first-error/stop status.
module assert_event_arbiter #(
    parameter int N_SRC      = 4,
    parameter int ID_W       = 8,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int SRC_W     = $clog2(N_SRC)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [N_SRC-1:0]        src_fire,
    input  logic [N_SRC*ID_W-1:0]   src_code,
    input  logic [CNT_W-1:0]        stop_threshold,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [SRC_W-1:0]        rpt_src,
    output logic [ID_W-1:0]         rpt_code,
    output logic [N_SRC-1:0]        sticky,
    output logic [CNT_W-1:0]        total_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    first_vld,
    output logic [SRC_W-1:0]        first_src,
    output logic [ID_W-1:0]         first_code,
    output logic                    stop_req
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] fire;
    logic [N_SRC-1:0] take;
    logic [N_SRC-1:0] drop;
    logic [N_SRC-1:0] grant;
    logic [ID_W-1:0]  pcode [N_SRC];

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_nxt;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_any;

    logic [SRC_W-1:0] mem_src  [FIFO_DEPTH];
    logic [ID_W-1:0]  mem_code [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             can_push;

    logic [SRC_W:0]   n_drop;
    logic [CNT_W-1:0] total_nxt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign fire = enable ? src_fire : '0;
    // A fire is accepted when the latch is free or is being granted away this very cycle.
    assign take = fire & (~pend | grant);
    assign drop = fire & pend & ~grant;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rpt_valid = ~empty;
    assign pop       = rpt_valid & rpt_ready;
    assign can_push  = ~full | pop;
    assign rpt_src   = empty ? '0 : mem_src[rd_ptr[AW-1:0]];
    assign rpt_code  = empty ? '0 : mem_code[rd_ptr[AW-1:0]];

    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        if (can_push) begin
            for (int k = 0; k < N_SRC; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_SRC) idx = idx - N_SRC;
                cand = SRC_W'(idx);
                if (!grant_any && pend[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign rr_nxt    = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
    assign total_nxt = sat_add(total_cnt, CNT_W'(1));

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (drop[i]) n_drop = n_drop + (SRC_W+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend       <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sticky     <= '0;
            total_cnt  <= '0;
            drop_cnt   <= '0;
            first_vld  <= 1'b0;
            first_src  <= '0;
            first_code <= '0;
            stop_req   <= 1'b0;
        end else if (clear) begin
            pend       <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sticky     <= '0;
            total_cnt  <= '0;
            drop_cnt   <= '0;
            first_vld  <= 1'b0;
            first_src  <= '0;
            first_code <= '0;
            stop_req   <= 1'b0;
        end else begin
            pend   <= (pend & ~grant) | take;
            sticky <= sticky | fire;
            if (grant_any) begin
                wr_ptr    <= wr_ptr + PW'(1);
                rr_ptr    <= rr_nxt;
                total_cnt <= total_nxt;
                if (!first_vld) begin
                    first_vld  <= 1'b1;
                    first_src  <= grant_idx;
                    first_code <= pcode[grant_idx];
                end
                if (stop_threshold != '0 && total_nxt == stop_threshold) stop_req <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (|drop) drop_cnt <= sat_add(drop_cnt, CNT_W'(n_drop));
        end
    end

    // Payload storage needs no reset: it is only observed behind pend / rpt_valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (take[i] && !clear) pcode[i] <= src_code[i*ID_W +: ID_W];
        end
        if (grant_any && !clear) begin
            mem_src[wr_ptr[AW-1:0]]  <= grant_idx;
            mem_code[wr_ptr[AW-1:0]] <= pcode[grant_idx];
        end
    end

endmodule

// File: tb/tb_assert_event_arbiter.sv
// Directed bench for assert_event_arbiter: one task per scenario with inline expected values.
module tb_assert_event_arbiter;

    localparam int N_SRC      = 4;
    localparam int ID_W       = 8;
    localparam int CNT_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int SRC_W      = 2;

    logic                  clock;
    logic                  reset_n;
    logic                  enable;
    logic                  clear;
    logic [N_SRC-1:0]      src_fire;
    logic [N_SRC*ID_W-1:0] src_code;
    logic [CNT_W-1:0]      stop_threshold;
    logic                  rpt_valid;
    logic                  rpt_ready;
    logic [SRC_W-1:0]      rpt_src;
    logic [ID_W-1:0]       rpt_code;
    logic [N_SRC-1:0]      sticky;
    logic [CNT_W-1:0]      total_cnt;
    logic [CNT_W-1:0]      drop_cnt;
    logic                  first_vld;
    logic [SRC_W-1:0]      first_src;
    logic [ID_W-1:0]       first_code;
    logic                  stop_req;

    int checks = 0;
    int errors = 0;

    assert_event_arbiter #(
        .N_SRC(N_SRC), .ID_W(ID_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .src_fire(src_fire), .src_code(src_code), .stop_threshold(stop_threshold),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_src(rpt_src), .rpt_code(rpt_code),
        .sticky(sticky), .total_cnt(total_cnt), .drop_cnt(drop_cnt),
        .first_vld(first_vld), .first_src(first_src), .first_code(first_code),
        .stop_req(stop_req)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; clear = 1'b0; src_fire = '0; src_code = '0;
        stop_threshold = '0; rpt_ready = 1'b0;
        #3;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", rpt_valid); end
        checks++; if ({sticky, total_cnt, drop_cnt} !== '0) begin errors++; $display("FAIL reset_status sticky=%0h total=%0h drop=%0h exp=0", sticky, total_cnt, drop_cnt); end
        checks++; if ({first_vld, first_src, first_code, stop_req} !== '0) begin errors++; $display("FAIL reset_first_stop got=%0h exp=0", {first_vld, first_src, first_code, stop_req}); end
        cyc(2);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        do_clear();
        rpt_ready = 1'b1;
        src_fire = 4'b0100; src_code = '0; src_code[16 +: 8] = 8'h5A;
        cyc();
        src_fire = '0;
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid got=%0h exp=0", rpt_valid); end
        cyc();
        checks++; if ({rpt_valid, rpt_src, rpt_code} !== {1'b1, 2'd2, 8'h5A}) begin errors++; $display("FAIL single_t2_head got=%0h/%0h/%0h exp=1/2/5a", rpt_valid, rpt_src, rpt_code); end
        checks++; if (total_cnt !== 16'd1) begin errors++; $display("FAIL single_total got=%0d exp=1", total_cnt); end
        checks++; if (sticky !== 4'b0100) begin errors++; $display("FAIL single_sticky got=%b exp=0100", sticky); end
        checks++; if ({first_vld, first_src, first_code} !== {1'b1, 2'd2, 8'h5A}) begin errors++; $display("FAIL single_first got=%0h/%0h/%0h exp=1/2/5a", first_vld, first_src, first_code); end
        cyc();
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL single_popped got=%0h exp=0", rpt_valid); end
    endtask

    task automatic test_all_fire();
        do_clear();
        rpt_ready = 1'b1;
        src_fire = 4'hF;
        for (int i = 0; i < N_SRC; i++) src_code[i*8 +: 8] = 8'(8'h10 + i);
        cyc();
        src_fire = '0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            checks++; if ({rpt_valid, rpt_src, rpt_code} !== {1'b1, 2'(k), 8'(8'h10 + k)}) begin errors++; $display("FAIL allfire_head%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, rpt_valid, rpt_src, rpt_code, k, 8'h10 + k); end
            cyc();
        end
        checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL allfire_drained got=%0h exp=0", rpt_valid); end
        checks++; if ({total_cnt, drop_cnt} !== {16'd4, 16'd0}) begin errors++; $display("FAIL allfire_counts total=%0d drop=%0d exp=4/0", total_cnt, drop_cnt); end
        // rr_ptr should be back at 0, so source 0 must win over source 3
        src_fire = 4'b1001; src_code[0 +: 8] = 8'hA0; src_code[24 +: 8] = 8'hA3;
        cyc();
        src_fire = '0;
        cyc();
        checks++; if ({rpt_valid, rpt_src, rpt_code} !== {1'b1, 2'd0, 8'hA0}) begin errors++; $display("FAIL allfire_rr_first got=%0h/%0h/%0h exp=1/0/a0", rpt_valid, rpt_src, rpt_code); end
        cyc();
        checks++; if ({rpt_valid, rpt_src, rpt_code} !== {1'b1, 2'd3, 8'hA3}) begin errors++; $display("FAIL allfire_rr_second got=%0h/%0h/%0h exp=1/3/a3", rpt_valid, rpt_src, rpt_code); end
        cyc();
        checks++; if (total_cnt !== 16'd6) begin errors++; $display("FAIL allfire_total6 got=%0d exp=6", total_cnt); end
    endtask

    task automatic test_drop();
        logic [9:0] exp_q [5];
        exp_q = '{{2'd0, 8'hC0}, {2'd0, 8'hC1}, {2'd0, 8'hC2}, {2'd0, 8'hC3}, {2'd1, 8'hB1}};
        do_clear();
        rpt_ready = 1'b0;
        src_fire = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            src_code[0 +: 8] = 8'(8'hC0 + k);
            cyc();
        end
        src_fire = '0;
        cyc(2);
        checks++; if ({total_cnt, drop_cnt} !== {16'd4, 16'd0}) begin errors++; $display("FAIL drop_fill total=%0d drop=%0d exp=4/0", total_cnt, drop_cnt); end
        src_fire = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            src_code[8 +: 8] = 8'(8'hB1 + k);
            cyc();
        end
        src_fire = '0;
        cyc();
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt got=%0d exp=2", drop_cnt); end
        checks++; if (total_cnt !== 16'd4) begin errors++; $display("FAIL drop_total_held got=%0d exp=4", total_cnt); end
        checks++; if (sticky !== 4'b0011) begin errors++; $display("FAIL drop_sticky got=%b exp=0011", sticky); end
        rpt_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if ({rpt_valid, rpt_src, rpt_code} !== {1'b1, exp_q[k]}) begin errors++; $display("FAIL drop_head%0d got=%0h/%0h/%0h exp=1/%0h", k, rpt_valid, rpt_src, rpt_code, exp_q[k]); end
            cyc();
        end
        checks++; if ({rpt_valid, total_cnt, drop_cnt} !== {1'b0, 16'd5, 16'd2}) begin errors++; $display("FAIL drop_end valid=%0h total=%0d drop=%0d exp=0/5/2", rpt_valid, total_cnt, drop_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_q [6];
        exp_q = '{{2'd0, 8'h20}, {2'd1, 8'h21}, {2'd2, 8'h22}, {2'd3, 8'h23}, {2'd0, 8'h30}, {2'd1, 8'h31}};
        do_clear();
        rpt_ready = 1'b0;
        src_fire = 4'hF;
        for (int i = 0; i < N_SRC; i++) src_code[i*8 +: 8] = 8'(8'h20 + i);
        cyc();
        src_fire = '0;
        cyc(5);
        checks++; if ({rpt_valid, rpt_src, rpt_code, total_cnt} !== {1'b1, 2'd0, 8'h20, 16'd4}) begin errors++; $display("FAIL bp_full got=%0h/%0h/%0h total=%0d exp=1/0/20 total=4", rpt_valid, rpt_src, rpt_code, total_cnt); end
        src_fire = 4'b0011; src_code[0 +: 8] = 8'h30; src_code[8 +: 8] = 8'h31;
        cyc();
        src_fire = '0;
        cyc(3);
        checks++; if ({rpt_src, rpt_code, total_cnt, drop_cnt} !== {2'd0, 8'h20, 16'd4, 16'd0}) begin errors++; $display("FAIL bp_held head=%0h/%0h total=%0d drop=%0d exp=0/20 4/0", rpt_src, rpt_code, total_cnt, drop_cnt); end
        rpt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if ({rpt_valid, rpt_src, rpt_code} !== {1'b1, exp_q[k]}) begin errors++; $display("FAIL bp_head%0d got=%0h/%0h/%0h exp=1/%0h", k, rpt_valid, rpt_src, rpt_code, exp_q[k]); end
            cyc();
        end
        checks++; if ({rpt_valid, total_cnt, drop_cnt} !== {1'b0, 16'd6, 16'd0}) begin errors++; $display("FAIL bp_end valid=%0h total=%0d drop=%0d exp=0/6/0", rpt_valid, total_cnt, drop_cnt); end
    endtask

    task automatic test_stop();
        do_clear();
        rpt_ready = 1'b1;
        stop_threshold = 16'd3;
        src_fire = 4'b0111;
        for (int i = 0; i < N_SRC; i++) src_code[i*8 +: 8] = 8'(8'h50 + i);
        cyc();
        src_fire = '0;
        cyc(2);
        checks++; if ({stop_req, total_cnt} !== {1'b0, 16'd2}) begin errors++; $display("FAIL stop_early stop=%0h total=%0d exp=0/2", stop_req, total_cnt); end
        cyc();
        checks++; if ({stop_req, total_cnt} !== {1'b1, 16'd3}) begin errors++; $display("FAIL stop_rise stop=%0h total=%0d exp=1/3", stop_req, total_cnt); end
        checks++; if ({first_src, first_code} !== {2'd0, 8'h50}) begin errors++; $display("FAIL stop_first got=%0h/%0h exp=0/50", first_src, first_code); end
        stop_threshold = '0;
        cyc(2);
        checks++; if (stop_req !== 1'b1) begin errors++; $display("FAIL stop_sticky got=%0h exp=1", stop_req); end
        clear = 1'b1; src_fire = 4'b1000;
        cyc();
        clear = 1'b0; src_fire = '0;
        checks++; if ({stop_req, total_cnt, drop_cnt} !== '0) begin errors++; $display("FAIL clear_counts stop=%0h total=%0d drop=%0d exp=0", stop_req, total_cnt, drop_cnt); end
        checks++; if ({first_vld, rpt_valid, sticky} !== '0) begin errors++; $display("FAIL clear_status first=%0h valid=%0h sticky=%b exp=0", first_vld, rpt_valid, sticky); end
        cyc(3);
        checks++; if ({rpt_valid, total_cnt} !== {1'b0, 16'd0}) begin errors++; $display("FAIL clear_fire_ignored valid=%0h total=%0d exp=0/0", rpt_valid, total_cnt); end
    endtask

    task automatic test_reset_mid();
        do_clear();
        rpt_ready = 1'b0;
        src_fire = 4'hF;
        for (int i = 0; i < N_SRC; i++) src_code[i*8 +: 8] = 8'(8'h40 + i);
        cyc();
        src_fire = '0;
        cyc(2);
        checks++; if ({rpt_valid, total_cnt} !== {1'b1, 16'd2}) begin errors++; $display("FAIL rstmid_queued valid=%0h total=%0d exp=1/2", rpt_valid, total_cnt); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({rpt_valid, rpt_src, rpt_code, total_cnt, sticky, first_vld} !== '0) begin errors++; $display("FAIL rstmid_async valid=%0h src=%0h code=%0h total=%0d sticky=%b first=%0h exp=0", rpt_valid, rpt_src, rpt_code, total_cnt, sticky, first_vld); end
        cyc();
        reset_n = 1'b1;
        rpt_ready = 1'b1;
        cyc(4);
        checks++; if ({rpt_valid, total_cnt} !== {1'b0, 16'd0}) begin errors++; $display("FAIL rstmid_no_report valid=%0h total=%0d exp=0/0", rpt_valid, total_cnt); end
        src_fire = 4'b0100; src_code[16 +: 8] = 8'h77;
        cyc();
        src_fire = '0;
        cyc();
        checks++; if ({rpt_valid, rpt_src, rpt_code, total_cnt} !== {1'b1, 2'd2, 8'h77, 16'd1}) begin errors++; $display("FAIL rstmid_new got=%0h/%0h/%0h total=%0d exp=1/2/77 total=1", rpt_valid, rpt_src, rpt_code, total_cnt); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_fire();
        test_drop();
        test_back_to_back();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
